// File: rtl/qu_uop.sv
// Micro-op encoding shared by the Qu front end: optype/ALU constants, RV32I
// opcodes and the packed uop_t with its INT/CONT and load/store views.
package qu_uop;

  localparam int UOP_WIDTH = 60;

  typedef enum logic [1:0] {
    OPT_INT   = 2'd0,
    OPT_CONT  = 2'd1,
    OPT_LOAD  = 2'd2,
    OPT_STORE = 2'd3
  } optype_e;

  typedef enum logic [1:0] {
    ALU_ADDER = 2'd0,
    ALU_SHIFT = 2'd1,
    ALU_COMP  = 2'd2,
    ALU_LOGIC = 2'd3
  } alu_unit_e;

  localparam logic [3:0] ALU_ADDITION    = 4'b0000;
  localparam logic [3:0] ALU_SUBTRACTION = 4'b1000;
  localparam logic [3:0] ALU_SLL         = 4'b0001;
  localparam logic [3:0] ALU_SRL         = 4'b0101;
  localparam logic [3:0] ALU_SRA         = 4'b1101;
  localparam logic [3:0] ALU_XOR         = 4'b0100;
  localparam logic [3:0] ALU_OR          = 4'b0110;
  localparam logic [3:0] ALU_AND         = 4'b0111;
  localparam logic [3:0] ALU_IS_EQ       = 4'b0000;
  localparam logic [3:0] ALU_IS_NE       = 4'b0001;
  localparam logic [3:0] ALU_IS_LT       = 4'b0100;
  localparam logic [3:0] ALU_IS_GE       = 4'b0101;
  localparam logic [3:0] ALU_IS_LTU      = 4'b0110;
  localparam logic [3:0] ALU_IS_GEU      = 4'b0111;

  localparam logic YES = 1'b1;
  localparam logic NO  = 1'b0;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // Both views keep optype/register/immediate fields at the same bit positions.
  typedef struct packed {
    optype_e     optype;
    logic [4:0]  rd;
    logic        rd_valid;
    logic [4:0]  rs1;
    logic        rs1_valid;
    logic [4:0]  rs2;
    logic        rs2_valid;
    logic [31:0] imm;
    logic        imm_valid;
    alu_unit_e   alu_unit;
    logic [3:0]  alu_op_sel;
    logic        alu_cu_input_opd3_opd4_sel;
  } uop_ic_t;

  typedef struct packed {
    optype_e     optype;
    logic [4:0]  rd;
    logic        rd_valid;
    logic [4:0]  rs1;
    logic        rs1_valid;
    logic [4:0]  rs2;
    logic        rs2_valid;
    logic [31:0] imm;
    logic        imm_valid;
    logic [2:0]  funct3;
    logic        ignore;
    logic [2:0]  rsvd;
  } uop_ldst_t;

  typedef union packed {
    uop_ic_t   ic;
    uop_ldst_t ldst;
  } uop_t;

  typedef struct packed {
    alu_unit_e  unit;
    logic [3:0] op;
  } alu_sel_t;

  // funct3 -> ALU unit/op for OP and OP-IMM.
  function automatic alu_sel_t alu_map(input logic [2:0] f3, input logic sub, input logic sra);
    alu_sel_t s;
    s.unit = ALU_ADDER;
    s.op   = ALU_ADDITION;
    case (f3)
      3'b000: s.op = sub ? ALU_SUBTRACTION : ALU_ADDITION;
      3'b001: begin s.unit = ALU_SHIFT; s.op = ALU_SLL; end
      3'b010: begin s.unit = ALU_COMP;  s.op = ALU_IS_LT; end
      3'b011: begin s.unit = ALU_COMP;  s.op = ALU_IS_LTU; end
      3'b100: begin s.unit = ALU_LOGIC; s.op = ALU_XOR; end
      3'b101: begin s.unit = ALU_SHIFT; s.op = sra ? ALU_SRA : ALU_SRL; end
      3'b110: begin s.unit = ALU_LOGIC; s.op = ALU_OR; end
      default: begin s.unit = ALU_LOGIC; s.op = ALU_AND; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/qu_decode_comb.sv
// Pure combinational RV32I -> uop_t translation; illegal encodings yield an
// all-zero micro-op with illegal_o set.
module qu_decode_comb
  import qu_uop::*;
(
  input  logic [31:0] instr_i,
  output uop_t        uop_o,
  output logic        illegal_o
);

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        f7_ok;

  assign opc   = instr_i[6:0];
  assign rd    = instr_i[11:7];
  assign f3    = instr_i[14:12];
  assign rs1   = instr_i[19:15];
  assign rs2   = instr_i[24:20];
  assign f7    = instr_i[31:25];
  assign f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  uop_ic_t   ic;
  uop_ldst_t ls;
  alu_sel_t  asel;
  logic      is_ls, ill;
  uop_t      uop;

  always_comb begin
    ic    = '0;
    ls    = '0;
    is_ls = 1'b0;
    ill   = 1'b0;
    asel  = alu_map(f3, 1'b0, f7[5]);
    uop   = '0;
    ic.rd = rd; ic.rs1 = rs1; ic.rs2 = rs2;
    ls.rd = rd; ls.rs1 = rs1; ls.rs2 = rs2;
    case (opc)
      OPC_OP: begin
        asel          = alu_map(f3, f7[5], f7[5]);
        ic.optype     = OPT_INT;
        ic.rd_valid   = 1'b1;
        ic.rs1_valid  = 1'b1;
        ic.rs2_valid  = 1'b1;
        ic.alu_unit   = asel.unit;
        ic.alu_op_sel = asel.op;
        ill           = !f7_ok;
      end
      OPC_OP_IMM: begin
        ic.optype     = OPT_INT;
        ic.rd_valid   = 1'b1;
        ic.rs1_valid  = 1'b1;
        ic.imm        = imm_i;
        ic.imm_valid  = 1'b1;
        ic.alu_unit   = asel.unit;
        ic.alu_op_sel = asel.op;
        // Only the shift forms carry a funct7 field.
        ill           = ((f3 == 3'b001) || (f3 == 3'b101)) && !f7_ok;
      end
      OPC_LUI, OPC_AUIPC: begin
        ic.optype     = OPT_INT;
        ic.rd_valid   = 1'b1;
        ic.imm        = imm_u;
        ic.imm_valid  = 1'b1;
        ic.alu_unit   = ALU_ADDER;
        ic.alu_op_sel = ALU_ADDITION;
        ic.alu_cu_input_opd3_opd4_sel = (opc == OPC_AUIPC) ? YES : NO;
      end
      OPC_BRANCH: begin
        ic.optype     = OPT_CONT;
        ic.rs1_valid  = 1'b1;
        ic.rs2_valid  = 1'b1;
        ic.imm        = imm_b;
        ic.imm_valid  = 1'b1;
        ic.alu_unit   = ALU_COMP;
        ic.alu_cu_input_opd3_opd4_sel = YES;
        case (f3)
          3'b000:  ic.alu_op_sel = ALU_IS_EQ;
          3'b001:  ic.alu_op_sel = ALU_IS_NE;
          3'b100:  ic.alu_op_sel = ALU_IS_LT;
          3'b101:  ic.alu_op_sel = ALU_IS_GE;
          3'b110:  ic.alu_op_sel = ALU_IS_LTU;
          3'b111:  ic.alu_op_sel = ALU_IS_GEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        ic.optype     = OPT_CONT;
        ic.rd_valid   = 1'b1;
        ic.rs1_valid  = (opc == OPC_JALR);
        ic.imm        = (opc == OPC_JALR) ? imm_i : imm_j;
        ic.imm_valid  = 1'b1;
        ic.alu_unit   = ALU_ADDER;
        ic.alu_op_sel = ALU_ADDITION;
        ic.alu_cu_input_opd3_opd4_sel = YES;
      end
      OPC_LOAD: begin
        is_ls        = 1'b1;
        ls.optype    = OPT_LOAD;
        ls.rd_valid  = 1'b1;
        ls.rs1_valid = 1'b1;
        ls.imm       = imm_i;
        ls.imm_valid = 1'b1;
        ls.funct3    = f3;
        ill          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        is_ls        = 1'b1;
        ls.optype    = OPT_STORE;
        ls.rs1_valid = 1'b1;
        ls.rs2_valid = 1'b1;
        ls.imm       = imm_s;
        ls.imm_valid = 1'b1;
        ls.funct3    = f3;
        ill          = (f3 >= 3'b011);
      end
      default: ill = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) ill = 1'b1;
    if (rd == 5'd0) begin
      ic.rd_valid = 1'b0;
      ls.rd_valid = 1'b0;
    end
    if (!ill) begin
      if (is_ls) uop.ldst = ls;
      else       uop.ic   = ic;
    end
  end

  assign uop_o     = uop;
  assign illegal_o = ill;

endmodule

// File: rtl/qu_decode.sv
// Qu decode stage: handshaked fetch -> decode -> dispatch with registered output.
// QU_DECODE_SKID_EN selects a 2-entry skid buffer with a registered in_ready.
module qu_decode
  import qu_uop::*;
#(
  parameter int XLEN  = 32,
  parameter int UOP_W = qu_uop::UOP_WIDTH
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [UOP_W-1:0] out_uop,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal
);

  typedef struct packed {
    uop_t            uop;
    logic [XLEN-1:0] pc;
    logic            ill;
  } ent_t;

  uop_t dec_uop;
  logic dec_ill;
  ent_t in_ent, head;
  logic push, pop;

  qu_decode_comb u_comb (
    .instr_i   (in_instr),
    .uop_o     (dec_uop),
    .illegal_o (dec_ill)
  );

  assign in_ent = '{uop: dec_uop, pc: in_pc, ill: dec_ill};
  assign pop    = out_valid && out_ready;

`ifdef QU_DECODE_SKID_EN
  ent_t [1:0] slot_q, slot_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rdy_q, rdy_d;

  assign in_ready = rdy_q;
  assign push     = in_valid && rdy_q;

  // A push while full cannot happen: rdy_q is already low at two entries.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          slot_d[cnt_q[0]] = in_ent;
          cnt_d            = cnt_q + 2'd1;
        end
        2'b01: begin
          slot_d[0] = slot_q[1];
          cnt_d     = cnt_q - 2'd1;
        end
        2'b11:   slot_d[0] = in_ent;
        default: ;
      endcase
    end
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b1;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign head      = slot_q[0];
`else
  ent_t ent_q, ent_d;
  logic vld_q, vld_d;

  assign in_ready = !vld_q || out_ready;
  assign push     = in_valid && in_ready;

  always_comb begin
    ent_d = ent_q;
    vld_d = vld_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (push) begin
      ent_d = in_ent;
      vld_d = 1'b1;
    end else if (pop) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
      vld_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign head      = ent_q;
`endif

  assign out_uop     = head.uop;
  assign out_pc      = head.pc;
  assign out_illegal = head.ill;

endmodule

// File: tb/tb_qu_decode.sv
// Table-driven bench for qu_decode with a scoreboard queue; build with
// +define+QU_DECODE_SKID_EN to check the skid-buffer configuration.
module tb_qu_decode;
  import qu_uop::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [59:0] out_uop;

  qu_decode #(.XLEN(32), .UOP_W(60)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

`ifdef QU_DECODE_SKID_EN
  localparam int HOLD_ACC = 2;
`else
  localparam int HOLD_ACC = 1;
`endif
  localparam int NV = 18;

  typedef struct { logic [31:0] instr; uop_t uop; logic ill; } vec_t;
  typedef struct { uop_t uop; logic [31:0] pc; logic ill; } exp_t;

  vec_t tv [NV];
  exp_t sb [$];
  uop_t cur_uop;
  logic cur_ill;
  int   n_chk = 0, n_fail = 0, n_out = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic uop_t mk_ic(optype_e t, logic [4:0] rd, logic rdv, logic [4:0] rs1, logic rs1v,
                                 logic [4:0] rs2, logic rs2v, logic [31:0] imm, logic immv,
                                 alu_unit_e u, logic [3:0] op, logic sel);
    uop_t r;
    r = '0;
    r.ic.optype = t; r.ic.rd = rd; r.ic.rd_valid = rdv; r.ic.rs1 = rs1; r.ic.rs1_valid = rs1v;
    r.ic.rs2 = rs2; r.ic.rs2_valid = rs2v; r.ic.imm = imm; r.ic.imm_valid = immv;
    r.ic.alu_unit = u; r.ic.alu_op_sel = op; r.ic.alu_cu_input_opd3_opd4_sel = sel;
    return r;
  endfunction

  function automatic uop_t mk_ls(optype_e t, logic [4:0] rd, logic rdv, logic [4:0] rs1,
                                 logic [4:0] rs2, logic rs2v, logic [31:0] imm, logic [2:0] f3);
    uop_t r;
    r = '0;
    r.ldst.optype = t; r.ldst.rd = rd; r.ldst.rd_valid = rdv; r.ldst.rs1 = rs1;
    r.ldst.rs1_valid = 1'b1; r.ldst.rs2 = rs2; r.ldst.rs2_valid = rs2v;
    r.ldst.imm = imm; r.ldst.imm_valid = 1'b1; r.ldst.funct3 = f3;
    return r;
  endfunction

  task automatic setv(input int i, input logic [31:0] instr, input uop_t u, input logic ill);
    tv[i].instr = instr; tv[i].uop = u; tv[i].ill = ill;
  endtask

  // Scoreboard: sampled mid-cycle, between the input drive and the next rising edge.
  always begin
    @(negedge clk); #3;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_uop", out_uop, e.uop);
          chk("out_pc", out_pc, e.pc);
          chk("out_illegal", out_illegal, e.ill);
        end
      end
      if (in_valid && in_ready) sb.push_back('{cur_uop, in_pc, cur_ill});
    end
  end

  task automatic offer(input int idx, input logic [31:0] pc, input int maxc, output bit ok);
    in_valid = 1'b1; in_instr = tv[idx].instr; in_pc = pc;
    cur_uop = tv[idx].uop; cur_ill = tv[idx].ill;
    ok = 1'b0;
    for (int c = 0; c < maxc && !ok; c++) begin
      #3; ok = in_ready;
      @(negedge clk);
    end
  endtask

  task automatic drain(input int maxc);
    for (int c = 0; c < maxc && sb.size() != 0; c++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_uop"}, out_uop, 0);
    chk({tag, "_out_pc"}, out_pc, 0);
    chk({tag, "_out_illegal"}, out_illegal, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int acc, c0, n0;
    uop_t z;
    z = '0;
    setv(0,  32'h002081B3, mk_ic(OPT_INT, 3, 1, 1, 1, 2, 1, 0, 0, ALU_ADDER, 4'b0000, 0), 0);
    setv(1,  32'h402081B3, mk_ic(OPT_INT, 3, 1, 1, 1, 2, 1, 0, 0, ALU_ADDER, 4'b1000, 0), 0);
    setv(2,  32'hFFC12283, mk_ls(OPT_LOAD, 5, 1, 2, 28, 0, 32'hFFFFFFFC, 3'b010), 0);
    setv(3,  32'h00208463, mk_ic(OPT_CONT, 8, 0, 1, 1, 2, 1, 8, 1, ALU_COMP, ALU_IS_EQ, 1), 0);
    setv(4,  32'h00000013, mk_ic(OPT_INT, 0, 0, 0, 1, 0, 0, 0, 1, ALU_ADDER, ALU_ADDITION, 0), 0);
    setv(5,  32'hFFFFFFFF, z, 1);
    setv(6,  32'h0020A463, z, 1);
    setv(7,  32'hFFF10093, mk_ic(OPT_INT, 1, 1, 2, 1, 31, 0, 32'hFFFFFFFF, 1, ALU_ADDER, ALU_ADDITION, 0), 0);
    setv(8,  32'h40335293, mk_ic(OPT_INT, 5, 1, 6, 1, 3, 0, 32'h00000403, 1, ALU_SHIFT, ALU_SRA, 0), 0);
    setv(9,  32'h123453B7, mk_ic(OPT_INT, 7, 1, 8, 0, 3, 0, 32'h12345000, 1, ALU_ADDER, ALU_ADDITION, 0), 0);
    setv(10, 32'h12345397, mk_ic(OPT_INT, 7, 1, 8, 0, 3, 0, 32'h12345000, 1, ALU_ADDER, ALU_ADDITION, 1), 0);
    setv(11, 32'h010000EF, mk_ic(OPT_CONT, 1, 1, 0, 0, 16, 0, 16, 1, ALU_ADDER, ALU_ADDITION, 1), 0);
    setv(12, 32'h00512423, mk_ls(OPT_STORE, 8, 0, 2, 5, 1, 8, 3'b010), 0);
    setv(13, 32'h00513423, z, 1);
    setv(14, 32'h202081B3, z, 1);
    setv(15, 32'h0020A1B3, mk_ic(OPT_INT, 3, 1, 1, 1, 2, 1, 0, 0, ALU_COMP, ALU_IS_LT, 0), 0);
    setv(16, 32'h002081B0, z, 1);
    setv(17, 32'h004280E7, mk_ic(OPT_CONT, 1, 1, 5, 1, 4, 0, 4, 1, ALU_ADDER, ALU_ADDITION, 1), 0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; cur_uop = '0; cur_ill = 1'b0;
    @(negedge clk); #3;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Full table streamed back to back: no bubbles, in order.
    out_ready = 1'b1;
    c0 = cyc; n0 = n_out;
    for (int i = 0; i < NV; i++) begin
      offer(i, 32'h1000 + 32'(i) * 4, 4, ok);
      chk("stream_accept", ok, 1);
    end
    in_valid = 1'b0;
    chk("stream_cycles", cyc - c0, NV);
    drain(10);
    chk("stream_count", n_out - n0, NV);

    // Back-pressure: outputs hold while out_ready is low.
    out_ready = 1'b0; acc = 0;
    for (int j = 0; j < 3; j++) begin
      offer(j, 32'h2000 + 32'(j) * 4, 3, ok);
      if (ok) acc++;
      else break;
    end
    in_valid = 1'b0;
    chk("hold_accepted", acc, HOLD_ACC);
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("hold_valid", out_valid, 1);
      chk("hold_uop", out_uop, tv[0].uop);
      chk("hold_pc", out_pc, 32'h2000);
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1; n0 = n_out;
    drain(10);
    chk("hold_drained", n_out - n0, acc);

    // Flush with the buffer full and an input offered.
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      offer(3 + j, 32'h3000 + 32'(j) * 4, 3, ok);
      if (!ok) break;
    end
    flush = 1'b1; in_valid = 1'b1; in_instr = tv[7].instr;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #3;
    chk("flush_full_valid", out_valid, 0);
    chk("flush_full_in_ready", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b1; n0 = n_out;
    repeat (4) @(negedge clk);
    chk("flush_full_no_out", n_out - n0, 0);

    // Flush with an empty buffer: the concurrent input is dropped.
    out_ready = 1'b0;
    flush = 1'b1; in_valid = 1'b1; in_instr = tv[7].instr; in_pc = 32'h4000;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #3;
    chk("flush_empty_valid", out_valid, 0);
    @(negedge clk);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    offer(7, 32'h5000, 3, ok);
    offer(8, 32'h5004, 1, ok);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1; n0 = n_out;
    repeat (4) @(negedge clk);
    chk("rst_no_out", n_out - n0, 0);
    offer(9, 32'h6000, 3, ok);
    in_valid = 1'b0;
    chk("post_rst_accept", ok, 1);
    drain(10);
    chk("post_rst_count", n_out - n0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
